// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer that gates a processor with one-cycle cpu_en pulses timed off tick_in.
// Optional breakpoint logic is compiled in with the BREAKPOINT_EN macro.
module cpu_run_controller #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic             run_prev_reg, step_prev_reg;
    logic             armed_reg;
    logic             cpu_en_reg, cpu_en_next;
    logic [CNT_W-1:0] count_reg;
    logic             run_edge, step_edge, tick_ok, bp_hit;

    // armed_reg stays low for the first clock after reset so a request held
    // through reset release is absorbed into the edge registers, not seen as an edge.
    assign run_edge  = armed_reg & run_req  & ~run_prev_reg;
    assign step_edge = armed_reg & step_req & ~step_prev_reg;
    assign tick_ok   = tick_in & ~cpu_en_reg;

`ifdef BREAKPOINT_EN
    logic skip_reg, skip_next;

    assign bp_hit = (pc_in == bp_addr) & ~skip_reg;

    // Skip-once: armed on entry to BREAK, consumed by the next issued cpu_en.
    always_comb begin
        skip_next = skip_reg;
        if (state_reg != ST_BREAK && state_next == ST_BREAK)
            skip_next = 1'b1;
        else if (cpu_en_next)
            skip_next = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            skip_reg <= 1'b0;
        else
            skip_reg <= skip_next;
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc_in, bp_addr};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_HALT;
            run_prev_reg  <= 1'b0;
            step_prev_reg <= 1'b0;
            armed_reg     <= 1'b0;
            cpu_en_reg    <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            run_prev_reg  <= run_req;
            step_prev_reg <= step_req;
            armed_reg     <= 1'b1;
            cpu_en_reg    <= cpu_en_next;
            count_reg     <= count_reg + {{(CNT_W-1){1'b0}}, cpu_en_reg};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_HALT, ST_BREAK: begin
                if (!halt_req) begin
                    if (step_edge)
                        state_next = ST_STEP;
                    else if (run_edge)
                        state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req)
                    state_next = ST_HALT;
                else if (tick_ok && bp_hit)
                    state_next = ST_BREAK;
            end
            ST_STEP: begin
                if (halt_req || tick_ok)
                    state_next = ST_HALT;
            end
            default: state_next = ST_HALT;
        endcase
    end

    // The enable is computed here and registered, so it lands one clock after the tick.
    always_comb begin
        cpu_en_next = 1'b0;
        case (state_reg)
            ST_RUN:  cpu_en_next = ~halt_req & tick_ok & ~bp_hit;
            ST_STEP: cpu_en_next = ~halt_req & tick_ok;
            default: cpu_en_next = 1'b0;
        endcase
    end

    assign cpu_en      = cpu_en_reg;
    assign state       = state_reg;
    assign cycle_count = count_reg;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized and directed bench for cpu_run_controller against a request-level reference model.
// Define BREAKPOINT_EN for both files to also exercise the breakpoint feature.
module tb_cpu_run_controller;

    localparam int CNT_W   = 4;
    localparam int PC_W    = 8;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_BREAK = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             tick_in  = 1'b0;
    logic             run_req  = 1'b0;
    logic             step_req = 1'b0;
    logic             halt_req = 1'b0;
    logic [PC_W-1:0]  pc_in    = '0;
    logic [PC_W-1:0]  bp_addr  = 8'h05;
    logic             cpu_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: controller mode, pending enable, pulse count, request history.
    int m_mode;
    bit m_en;
    int m_cnt;
    bit m_prev_run, m_prev_step, m_fresh, m_skip;

    cpu_run_controller #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .tick_in     (tick_in),
        .run_req     (run_req),
        .step_req    (step_req),
        .halt_req    (halt_req),
        .pc_in       (pc_in),
        .bp_addr     (bp_addr),
        .cpu_en      (cpu_en),
        .state       (state),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_mode = M_HALT; m_en = 0; m_cnt = 0;
        m_prev_run = 0; m_prev_step = 0; m_fresh = 1; m_skip = 0;
    endtask

    // Applies the controller rules to the inputs seen at one rising clock.
    task automatic model_clock();
        bit re, se, tk, hit;
        re  = !m_fresh && run_req  && !m_prev_run;
        se  = !m_fresh && step_req && !m_prev_step;
        tk  = tick_in && !m_en;
        hit = 0;
`ifdef BREAKPOINT_EN
        hit = (pc_in == bp_addr) && !m_skip;
`endif
        m_cnt = (m_cnt + (m_en ? 1 : 0)) % CNT_MOD;
        m_en  = 0;
        if (m_mode == M_RUN) begin
            if (halt_req) m_mode = M_HALT;
            else if (tk && hit) begin m_mode = M_BREAK; m_skip = 1; end
            else if (tk) begin m_en = 1; m_skip = 0; end
        end else if (m_mode == M_STEP) begin
            if (halt_req) m_mode = M_HALT;
            else if (tk) begin m_en = 1; m_skip = 0; m_mode = M_HALT; end
        end else if (!halt_req) begin
            if (se) m_mode = M_STEP;
            else if (re) m_mode = M_RUN;
        end
        m_prev_run = run_req; m_prev_step = step_req; m_fresh = 0;
    endtask

    task automatic drive(input logic r, input logic s, input logic h, input logic t);
        run_req = r; step_req = s; halt_req = h; tick_in = t;
        @(posedge clock);
        model_clock();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; run_req = 1'b1;
        #2;
        n_checks++;
        if (state !== 2'b00 || cpu_en !== 1'b0 || cycle_count !== '0) begin
            n_fail++;
            $display("FAIL reset_async: state=%b en=%b cnt=%0d required 00/0/0", state, cpu_en, cycle_count);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, (i % 2 == 1));
            n_checks++;
            if (state !== 2'b00 || cpu_en !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_held_run: cycle %0d state=%b en=%b required 00/0", i, state, cpu_en);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_run();
        run_req = 1'b0;
        apply_reset();
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        n_checks++;
        if (state !== 2'b01) begin
            n_fail++;
            $display("FAIL run_enter: state=%b required 01", state);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 1);
            n_checks++;
            if (cpu_en !== 1'b1 || state !== 2'b01) begin
                n_fail++;
                $display("FAIL run_tick%0d: en=%b state=%b required 1/01", k, cpu_en, state);
            end
            for (int j = 0; j < 3; j++) begin
                drive(1, 0, 0, 0);
                n_checks++;
                if (cpu_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL run_idle%0d_%0d: en=%b required 0", k, j, cpu_en);
                end
            end
        end
        n_checks++;
        if (cycle_count !== 4'd5) begin
            n_fail++;
            $display("FAIL run_count: cnt=%0d required 5", cycle_count);
        end
        $display("test_run done, cycle_count=%0d", cycle_count);
    endtask

    task automatic test_step();
        run_req = 1'b0;
        apply_reset();
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        n_checks++;
        if (state !== 2'b10) begin
            n_fail++;
            $display("FAIL step_enter: state=%b required 10", state);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        n_checks++;
        if (cpu_en !== 1'b1 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL step_pulse: en=%b state=%b required 1/00", cpu_en, state);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, (i == 2));
            n_checks++;
            if (cpu_en !== 1'b0 || state !== 2'b00 || cycle_count !== 4'd1) begin
                n_fail++;
                $display("FAIL step_after%0d: en=%b state=%b cnt=%0d required 0/00/1", i, cpu_en, state, cycle_count);
            end
        end
        $display("test_step done");
    endtask

    task automatic test_halt_tick();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 1);
        n_checks++;
        if (cpu_en !== 1'b0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL halt_with_tick: en=%b state=%b required 0/00", cpu_en, state);
        end
        drive(1, 0, 0, 1);
        n_checks++;
        if (cpu_en !== 1'b0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL halt_stays: en=%b state=%b required 0/00", cpu_en, state);
        end
        $display("test_halt_tick done");
    endtask

    task automatic test_priority();
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        n_checks++;
        if (state !== 2'b10) begin
            n_fail++;
            $display("FAIL step_over_run: state=%b required 10", state);
        end
        drive(1, 1, 1, 0);
        drive(1, 1, 0, 1);
        n_checks++;
        if (state !== 2'b00 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL step_abort: state=%b en=%b required 00/0", state, cpu_en);
        end
        drive(0, 0, 0, 0);
        drive(1, 0, 1, 0);
        n_checks++;
        if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL halt_blocks_run: state=%b required 00", state);
        end
        drive(1, 0, 0, 1);
        n_checks++;
        if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL no_edge_after_halt: state=%b required 00", state);
        end
        $display("test_priority done");
    endtask

    task automatic test_reset_mid_run();
        run_req = 1'b0;
        apply_reset();
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        tick_in = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (cpu_en !== 1'b0 || cycle_count !== '0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_run: en=%b cnt=%0d state=%b required 0/0/00", cpu_en, cycle_count, state);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_pending: en=%b required 0", cpu_en);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, (i % 3 == 0));
            n_checks++;
            if (state !== 2'b00 || cpu_en !== 1'b0 || cycle_count !== '0) begin
                n_fail++;
                $display("FAIL reset_release_held%0d: state=%b en=%b cnt=%0d required 00/0/0", i, state, cpu_en, cycle_count);
            end
        end
        $display("test_reset_mid_run done");
    endtask

    task automatic test_wrap();
        run_req = 1'b0;
        apply_reset();
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 0, 1);
            drive(1, 0, 0, 0);
            n_checks++;
            if (cycle_count !== CNT_W'((i + 1) % CNT_MOD)) begin
                n_fail++;
                $display("FAIL count_wrap%0d: cnt=%0d required %0d", i, cycle_count, (i + 1) % CNT_MOD);
            end
        end
        drive(0, 0, 1, 0);
        $display("test_wrap done, cycle_count=%0d", cycle_count);
    endtask

`ifdef BREAKPOINT_EN
    task automatic test_breakpoint();
        run_req = 1'b0;
        apply_reset();
        bp_addr = 8'h05; pc_in = 8'h05;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        n_checks++;
        if (state !== 2'b11 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_enter: state=%b en=%b required 11/0", state, cpu_en);
        end
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        n_checks++;
        if (state !== 2'b01 || cpu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_skip_once: state=%b en=%b required 01/1", state, cpu_en);
        end
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        n_checks++;
        if (state !== 2'b11 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_rehit: state=%b en=%b required 11/0", state, cpu_en);
        end
        pc_in = '0;
        $display("test_breakpoint done");
    endtask
`endif

    task automatic test_random();
        logic r, s, h, t;
        logic prev_en;
        int   gap, pulses;
        run_req = 1'b0;
        apply_reset();
        r = 0; s = 0; prev_en = 0; pulses = 0;
        gap = $urandom_range(1, 4);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) r = ~r;
            if ($urandom_range(0, 7) == 0) s = ~s;
            h = ($urandom_range(0, 11) == 0);
            t = (gap == 0);
            if (gap == 0) gap = $urandom_range(1, 4);
            else gap--;
            pc_in = PC_W'($urandom_range(0, 7));
            drive(r, s, h, t);
            n_checks++;
            if (state !== 2'(m_mode) || cpu_en !== m_en || cycle_count !== CNT_W'(m_cnt)) begin
                n_fail++;
                $display("FAIL random%0d: state=%b en=%b cnt=%0d required %0d/%0d/%0d",
                         i, state, cpu_en, cycle_count, m_mode, m_en, m_cnt);
            end
            n_checks++;
            if (cpu_en === 1'b1 && prev_en === 1'b1) begin
                n_fail++;
                $display("FAIL en_back_to_back%0d: en high two clocks, required single pulse", i);
            end
            if (cpu_en === 1'b1) pulses++;
            prev_en = cpu_en;
        end
        pc_in = '0;
        $display("test_random done, %0d cpu_en pulses", pulses);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_step();
        test_halt_tick();
        test_priority();
        test_reset_mid_run();
        test_wrap();
`ifdef BREAKPOINT_EN
        test_breakpoint();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
